// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared constants for the multicycle RISC-V control path.
//   state_t      - main FSM state encoding
//   OP_*         - instr[6:0] major opcodes handled by the core
//   ALUOP_*      - 2-bit ALU_opcode handed to the ALU decoder
//   SRC_A_*, SRC_B_*, RES_* - datapath mux select encodings
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/main_fsm.sv
// main_fsm: Moore control FSM for the multicycle, single-port-memory RISC-V
// core (lw, sw, R-type, I-type ALU, beq, jal).
// Ports:
//   clk, rst_n      - core clock, asynchronous active-low reset
//   opcode          - instr[6:0] from the instruction register
//   zero            - ALU zero flag (branch decision)
//   mem_ready       - memory finishes the current fetch/read/write this cycle
//   ALU_opcode      - add / subtract / funct-decoded, to the ALU decoder
//   alu_src_a/b     - ALU operand selects
//   result_src      - result mux select
//   adr_src         - memory address select (0 PC, 1 ALUOut)
//   ir_write, pc_write, reg_write, mem_write - datapath write strobes
//   instr_retire    - one-cycle pulse as an instruction completes
//   illegal_instr   - one-cycle pulse on an unsupported opcode
module main_fsm
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] ALU_opcode,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       instr_retire,
  output logic       illegal_instr
);

  state_t state, state_next;

  // NOTE: state flops use non-blocking assignments; the combinational block
  // below uses blocking assignments with every output defaulted first, so no
  // latch can be inferred on any path through the case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next    = S_FETCH;
    ALU_opcode    = ALUOP_ADD;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_RS2;
    result_src    = RES_ALUOUT;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    mem_write     = 1'b0;
    instr_retire  = 1'b0;
    illegal_instr = 1'b0;

    unique case (state)
      S_FETCH: begin
        // PC + 4 is computed while the instruction is read; both the IR and
        // the PC update only once memory actually delivers the word.
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        state_next = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target oldPC + imm is precomputed into ALUOut here.
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_R:              state_next = S_EXECUTER;
          OP_I:              state_next = S_EXECUTEI;
          OP_BRANCH:         state_next = S_BEQ;
          OP_JAL:            state_next = S_JAL;
          default: begin
            illegal_instr = 1'b1;
            state_next    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        // opcode[5] is the only bit separating store from load.
        state_next = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        state_next = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src   = RES_MEMDATA;
        reg_write    = 1'b1;
        instr_retire = 1'b1;
        state_next   = S_FETCH;
      end
      S_MEMWRITE: begin
        // The write strobe stays up for the whole handshake; the store
        // retires only in the cycle memory accepts it.
        adr_src      = 1'b1;
        mem_write    = 1'b1;
        instr_retire = mem_ready;
        state_next   = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_RS2;
        ALU_opcode = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        ALU_opcode = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write    = 1'b1;
        instr_retire = 1'b1;
        state_next   = S_FETCH;
      end
      S_BEQ: begin
        // PC takes the precomputed target from ALUOut only when rs1 == rs2.
        alu_src_a    = SRC_A_RS1;
        alu_src_b    = SRC_B_RS2;
        ALU_opcode   = ALUOP_SUB;
        pc_write     = zero;
        instr_retire = 1'b1;
        state_next   = S_FETCH;
      end
      S_JAL: begin
        // Target (already in ALUOut) goes to PC while oldPC + 4 is formed
        // for the link register written in ALUWB.
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_FOUR;
        pc_write   = 1'b1;
        state_next = S_ALUWB;
      end
      default: state_next = S_FETCH;
    endcase

    // The state register already forces FETCH selects during reset; the
    // strobes are also killed so a mem_ready seen in reset writes nothing.
    if (!rst_n) begin
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      reg_write     = 1'b0;
      mem_write     = 1'b0;
      instr_retire  = 1'b0;
      illegal_instr = 1'b0;
    end
  end

endmodule

// File: tb/tb_main_fsm.sv
// tb_main_fsm: table-driven, scoreboarded bench for main_fsm. Each table row
// gives one cycle of inputs and the full expected output word; expectations
// are queued when the row is driven and compared at the following negedge.
module tb_main_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic [1:0] ALU_opcode, alu_src_a, alu_src_b, result_src;
  logic       adr_src, ir_write, pc_write, reg_write, mem_write;
  logic       instr_retire, illegal_instr;

  main_fsm dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .ALU_opcode   (ALU_opcode),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .result_src   (result_src),
    .adr_src      (adr_src),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .reg_write    (reg_write),
    .mem_write    (mem_write),
    .instr_retire (instr_retire),
    .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  // Packed order: alu_op, src_a, src_b, res, adr, irw, pcw, rw, mw, ret, ill
  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] res;
    logic       adr;
    logic       irw;
    logic       pcw;
    logic       rw;
    logic       mw;
    logic       ret;
    logic       ill;
  } outs_t;

  typedef struct packed {
    logic [6:0] opc;
    logic       z;
    logic       rdy;
    outs_t      exp;
  } vec_t;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b0000000;

  outs_t act;
  assign act = {ALU_opcode, alu_src_a, alu_src_b, result_src, adr_src,
                ir_write, pc_write, reg_write, mem_write, instr_retire,
                illegal_instr};

  int    errors = 0;
  int    checks = 0;
  outs_t exp_q[$];
  int    tag_q[$];
  vec_t  vecs[$];

  task automatic check(input string name, input outs_t a, input outs_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got alu=%b a=%b b=%b res=%b adr=%b ir/pc/rw/mw/ret/ill=%b%b%b%b%b%b, want alu=%b a=%b b=%b res=%b adr=%b ir/pc/rw/mw/ret/ill=%b%b%b%b%b%b",
               name, a.alu_op, a.src_a, a.src_b, a.res, a.adr, a.irw, a.pcw,
               a.rw, a.mw, a.ret, a.ill, e.alu_op, e.src_a, e.src_b, e.res,
               e.adr, e.irw, e.pcw, e.rw, e.mw, e.ret, e.ill);
    end
  endtask

  // Literal expected words for each state, written from the state table.
  function automatic vec_t mk(input logic [6:0] opc, input logic z,
                              input logic rdy, input logic [14:0] e);
    vec_t v;
    v.opc = opc; v.z = z; v.rdy = rdy; v.exp = outs_t'(e);
    return v;
  endfunction
  //                                      alu a  b  res adr irw pcw rw mw ret ill
  function automatic vec_t f_fetch(input logic [6:0] o, input logic r);
    return mk(o, 1'b0, r, {2'b00, 2'b00, 2'b10, 2'b10, 1'b0, r, r, 4'b0000});
  endfunction
  function automatic vec_t f_dec(input logic [6:0] o, input logic ill);
    return mk(o, 1'b0, 1'b1, {2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 5'b00000, ill});
  endfunction
  function automatic vec_t f_madr(input logic [6:0] o);
    return mk(o, 1'b0, 1'b1, {2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 6'b000000});
  endfunction
  function automatic vec_t f_mrd(input logic r);
    return mk(LW, 1'b0, r, {2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 6'b000000});
  endfunction
  function automatic vec_t f_mwb();
    return mk(LW, 1'b0, 1'b1, {2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 6'b001010});
  endfunction
  function automatic vec_t f_mwr(input logic r);
    return mk(SW, 1'b0, r, {2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 4'b0001, r, 1'b0});
  endfunction
  function automatic vec_t f_exr();
    return mk(RT, 1'b0, 1'b1, {2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 6'b000000});
  endfunction
  function automatic vec_t f_exi();
    return mk(IT, 1'b0, 1'b1, {2'b10, 2'b10, 2'b01, 2'b00, 1'b0, 6'b000000});
  endfunction
  function automatic vec_t f_aluwb(input logic [6:0] o);
    return mk(o, 1'b0, 1'b1, {2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 6'b001010});
  endfunction
  function automatic vec_t f_beq(input logic z);
    return mk(BQ, z, 1'b1, {2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, z, 4'b0010});
  endfunction
  function automatic vec_t f_jal();
    return mk(JL, 1'b0, 1'b1, {2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 6'b010000});
  endfunction

  localparam outs_t RST_EXP  = outs_t'({2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 6'b000000});
  localparam outs_t STALL_EXP = outs_t'({2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 6'b000000});

  task automatic drive(input vec_t v, input int tag);
    opcode    = v.opc;
    zero      = v.z;
    mem_ready = v.rdy;
    exp_q.push_back(v.exp);
    tag_q.push_back(tag);
  endtask

  task automatic expect_now(input outs_t e, input int tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic compare();
    outs_t e;
    int    t;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: got empty queue, want a pending entry");
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check($sformatf("vec%0d", t), act, e);
  endtask

  // One cycle: drive just after the edge, compare at the opposite edge.
  task automatic apply(input vec_t v, input int tag);
    drive(v, tag);
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; opcode = BAD; zero = 1'b0; mem_ready = 1'b1;
    #1;
    // Reset state with mem_ready high: FETCH selects, no strobes.
    expect_now(RST_EXP, 0);
    compare();
    @(posedge clk); @(negedge clk);
    mem_ready = 1'b0;
    rst_n     = 1'b1;
    @(posedge clk); #1;

    // lw, 5 cycles
    vecs.push_back(f_fetch(LW, 1'b1)); vecs.push_back(f_dec(LW, 1'b0));
    vecs.push_back(f_madr(LW));        vecs.push_back(f_mrd(1'b1));
    vecs.push_back(f_mwb());
    // sw with three not-ready cycles in MEMWRITE
    vecs.push_back(f_fetch(SW, 1'b1)); vecs.push_back(f_dec(SW, 1'b0));
    vecs.push_back(f_madr(SW));
    vecs.push_back(f_mwr(1'b0)); vecs.push_back(f_mwr(1'b0));
    vecs.push_back(f_mwr(1'b0)); vecs.push_back(f_mwr(1'b1));
    // beq taken, then not taken
    vecs.push_back(f_fetch(BQ, 1'b1)); vecs.push_back(f_dec(BQ, 1'b0));
    vecs.push_back(f_beq(1'b1));
    vecs.push_back(f_fetch(BQ, 1'b1)); vecs.push_back(f_dec(BQ, 1'b0));
    vecs.push_back(f_beq(1'b0));
    // R-type then addi
    vecs.push_back(f_fetch(RT, 1'b1)); vecs.push_back(f_dec(RT, 1'b0));
    vecs.push_back(f_exr());           vecs.push_back(f_aluwb(RT));
    vecs.push_back(f_fetch(IT, 1'b1)); vecs.push_back(f_dec(IT, 1'b0));
    vecs.push_back(f_exi());           vecs.push_back(f_aluwb(IT));
    // jal
    vecs.push_back(f_fetch(JL, 1'b1)); vecs.push_back(f_dec(JL, 1'b0));
    vecs.push_back(f_jal());           vecs.push_back(f_aluwb(JL));
    // illegal opcode, then a two-cycle fetch stall, then a beq
    vecs.push_back(f_fetch(BAD, 1'b1)); vecs.push_back(f_dec(BAD, 1'b1));
    vecs.push_back(f_fetch(BQ, 1'b0));  vecs.push_back(f_fetch(BQ, 1'b0));
    vecs.push_back(f_fetch(BQ, 1'b1));  vecs.push_back(f_dec(BQ, 1'b0));
    vecs.push_back(f_beq(1'b0));
    // lw with one MEMREAD wait
    vecs.push_back(f_fetch(LW, 1'b1)); vecs.push_back(f_dec(LW, 1'b0));
    vecs.push_back(f_madr(LW));        vecs.push_back(f_mrd(1'b0));
    vecs.push_back(f_mrd(1'b1));       vecs.push_back(f_mwb());

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i + 1);

    // Reset in the middle of a stalled lw (sitting in MEMREAD).
    apply(f_fetch(LW, 1'b1), 101);
    apply(f_dec(LW, 1'b0), 102);
    apply(f_madr(LW), 103);
    drive(f_mrd(1'b0), 104);
    @(negedge clk);
    compare();
    #2;
    mem_ready = 1'b1;
    rst_n     = 1'b0;
    expect_now(RST_EXP, 105);
    #1;
    compare();
    @(posedge clk); #1;
    expect_now(RST_EXP, 106);
    compare();
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n     = 1'b1;
    expect_now(STALL_EXP, 107);
    #1;
    compare();
    @(posedge clk); #1;
    // Execution resumes with a fresh fetch.
    apply(f_fetch(RT, 1'b1), 108);
    apply(f_dec(RT, 1'b0), 109);
    apply(f_exr(), 110);
    apply(f_aluwb(RT), 111);
    apply(f_fetch(RT, 1'b0), 112);

    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
